// File: rtl/nios_onchip_ram_pkg.sv
// nios_onchip_ram_pkg: shared types and helpers for the dual-port burst on-chip RAM
// Provides the s1 state encoding, the byte-lane count helper and the
// per-lane collision merge used when both ports write the same word.
package nios_onchip_ram_pkg;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} s1_state_t;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // s1 owns every lane it enables on a same-word collision; s2 keeps the rest
    function automatic logic merge_be(input logic s1_lane, input logic s2_lane, input logic collide);
        return s2_lane & ~(collide & s1_lane);
    endfunction

endpackage

// File: rtl/nios_onchip_ram_burst_ctrl.sv
// nios_onchip_ram_burst_ctrl: s1 burst FSM, beat counter and wrapping address generator
// Ports: clk/reset, active (unfrozen cycle), s1 command inputs,
// s1_waitrequest, rd_en/wr_en strobes and the word address acc_addr they apply to.
module nios_onchip_ram_burst_ctrl
    import nios_onchip_ram_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4096,
    parameter int BURST_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [BURST_W-1:0] s1_burstcount,
    output logic              s1_waitrequest,
    output logic              rd_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] acc_addr
);

    s1_state_t          state;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  next_addr;
    logic [BURST_W-1:0] rem;
    logic [BURST_W-1:0] beats;
    logic               idle;

    always_comb begin
        idle           = state == IDLE;
        beats          = s1_burstcount == '0 ? BURST_W'(1) : s1_burstcount;
        s1_waitrequest = ~active | (state == RD_BURST);
        wr_en          = active & (state != RD_BURST) & s1_chipselect & s1_write;
        rd_en          = active & (idle ? s1_chipselect & s1_read & ~s1_write : state == RD_BURST);
        acc_addr       = idle ? s1_address : addr_q;
        next_addr      = acc_addr == ADDR_W'(DEPTH - 1) ? '0 : acc_addr + 1'b1;
    end

    // rem counts beats still owed after the current one; the beat issued with rem == 1 is the last
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            rem    <= '0;
        end else if (rd_en | wr_en) begin
            addr_q <= next_addr;
            if (idle) begin
                rem   <= beats - 1'b1;
                state <= beats > BURST_W'(1) ? (wr_en ? WR_BURST : RD_BURST) : IDLE;
            end else begin
                rem <= rem - 1'b1;
                if (rem == BURST_W'(1))
                    state <= IDLE;
            end
        end
    end

endmodule

// File: rtl/nios_onchip_ram_burst_dp.sv
// nios_onchip_ram_burst_dp: dual-port Avalon-MM on-chip RAM, s1 bursting, s2 single-beat
// Ports: clk, reset (sync, active-high), reset_req/clken freeze controls,
// s1 burst slave (address/byteenable/chipselect/read/write/writedata/burstcount,
// waitrequest/readdata/readdatavalid), s2 single-beat slave (no waitrequest).
module nios_onchip_ram_burst_dp
    import nios_onchip_ram_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 12,
    parameter int    DEPTH     = 4096,
    parameter int    BURST_W   = 4,
    parameter int    OUT_REG   = 0,
    parameter string INIT_FILE = "nios_onchip_ram.hex"
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          reset_req,
    input  logic                          clken,
    input  logic [ADDR_W-1:0]             s1_address,
    input  logic [be_width(DATA_W)-1:0]   s1_byteenable,
    input  logic                          s1_chipselect,
    input  logic                          s1_read,
    input  logic                          s1_write,
    input  logic [DATA_W-1:0]             s1_writedata,
    input  logic [BURST_W-1:0]            s1_burstcount,
    output logic                          s1_waitrequest,
    output logic [DATA_W-1:0]             s1_readdata,
    output logic                          s1_readdatavalid,
    input  logic [ADDR_W-1:0]             s2_address,
    input  logic [be_width(DATA_W)-1:0]   s2_byteenable,
    input  logic                          s2_chipselect,
    input  logic                          s2_read,
    input  logic                          s2_write,
    input  logic [DATA_W-1:0]             s2_writedata,
    output logic [DATA_W-1:0]             s2_readdata,
    output logic                          s2_readdatavalid
);

    localparam int BE_W  = be_width(DATA_W);
    localparam int IDX_W = $clog2(DEPTH);

    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

    logic              active;
    logic              rd1_en, wr1_en, rd2_en, wr2_en;
    logic              in1, in2, we1, we2, collide;
    logic [ADDR_W-1:0] a1;
    logic              rd1_v, rd2_v;
    logic [DATA_W-1:0] rd1_d, rd2_d;

    assign active = clken & ~reset_req & ~reset;

    nios_onchip_ram_burst_ctrl #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .BURST_W (BURST_W)
    ) u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .s1_address     (s1_address),
        .s1_chipselect  (s1_chipselect),
        .s1_read        (s1_read),
        .s1_write       (s1_write),
        .s1_burstcount  (s1_burstcount),
        .s1_waitrequest (s1_waitrequest),
        .rd_en          (rd1_en),
        .wr_en          (wr1_en),
        .acc_addr       (a1)
    );

    // Addresses at or above DEPTH never touch the array: writes drop, reads yield zero
    always_comb begin
        wr2_en  = active & s2_chipselect & s2_write;
        rd2_en  = active & s2_chipselect & s2_read & ~s2_write;
        in1     = {1'b0, a1} < (ADDR_W + 1)'(DEPTH);
        in2     = {1'b0, s2_address} < (ADDR_W + 1)'(DEPTH);
        we1     = wr1_en & in1;
        we2     = wr2_en & in2;
        collide = we1 & we2 & (a1 == s2_address);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we2 && merge_be(s1_byteenable[i], s2_byteenable[i], collide))
                mem[s2_address[IDX_W-1:0]][8*i +: 8] <= s2_writedata[8*i +: 8];
            if (we1 && s1_byteenable[i])
                mem[a1[IDX_W-1:0]][8*i +: 8] <= s1_writedata[8*i +: 8];
        end
    end

    // Array read registers; nonblocking update of the array makes read-during-write return old data
    always_ff @(posedge clk) begin
        if (reset) begin
            rd1_v <= 1'b0;
            rd2_v <= 1'b0;
            rd1_d <= '0;
            rd2_d <= '0;
        end else if (active) begin
            rd1_v <= rd1_en;
            rd2_v <= rd2_en;
            rd1_d <= rd1_en && in1 ? mem[a1[IDX_W-1:0]] : '0;
            rd2_d <= rd2_en && in2 ? mem[s2_address[IDX_W-1:0]] : '0;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              o1_v, o2_v;
        logic [DATA_W-1:0] o1_d, o2_d;
        always_ff @(posedge clk) begin
            if (reset) begin
                o1_v <= 1'b0;
                o2_v <= 1'b0;
                o1_d <= '0;
                o2_d <= '0;
            end else if (active) begin
                o1_v <= rd1_v;
                o2_v <= rd2_v;
                o1_d <= rd1_d;
                o2_d <= rd2_d;
            end
        end
        assign s1_readdata      = o1_d;
        assign s2_readdata      = o2_d;
        assign s1_readdatavalid = active & o1_v;
        assign s2_readdatavalid = active & o2_v;
    end else begin : g_no_out_reg
        assign s1_readdata      = rd1_d;
        assign s2_readdata      = rd2_d;
        assign s1_readdatavalid = active & rd1_v;
        assign s2_readdatavalid = active & rd2_v;
    end

endmodule

// File: doc/nios_onchip_ram_burst_dp.md
Name: nios_onchip_ram_burst_dp

Overview:
Parametrised dual-port Avalon-MM on-chip RAM for the Nios subsystem. Next generation of the single-port on-chip RAM.
- Port s1: linear read and write bursts with waitrequest and readdatavalid. Serves the CPU instruction/data master.
- Port s2: single-beat accesses with readdatavalid. Serves the DMA or peripheral side.
- Configurable width, depth, output register and init file.
- Same clken / reset_req freeze semantics as the existing RAM.

Parameters:
DATA_W, 32, data width; multiple of 8; BE_W = DATA_W/8
ADDR_W, 12, word address width
DEPTH, 4096, words; 2 ≤ DEPTH ≤ 2**ADDR_W
BURST_W, 4, s1_burstcount width; max burst 2**(BURST_W-1) = 8
OUT_REG, 0, 1 adds an output register stage (+1 read latency)
INIT_FILE, "nios_onchip_ram.hex", memory init file

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
reset_req  in  1  1 = freeze block
clken  in  1  0 = freeze block
s1_address  in  ADDR_W  word address
s1_byteenable  in  BE_W  byte lanes
s1_chipselect  in  1  select
s1_read  in  1  read request
s1_write  in  1  write request
s1_writedata  in  DATA_W  write data
s1_burstcount  in  BURST_W  beats; 0 treated as 1
s1_waitrequest  out  1  1 = command not accepted
s1_readdata  out  DATA_W  read data
s1_readdatavalid  out  1  read beat valid
s2_address  in  ADDR_W  word address
s2_byteenable  in  BE_W  byte lanes
s2_chipselect  in  1  select
s2_read  in  1  read request
s2_write  in  1  write request
s2_writedata  in  DATA_W  write data
s2_readdata  out  DATA_W  read data
s2_readdatavalid  out  1  read beat valid

Behaviour:
- Active cycle = clken & ~reset_req & ~reset. In a frozen cycle:
  - No RAM access.
  - FSM, counters and pipelines hold.
  - s1_waitrequest = 1; both readdatavalid outputs = 0.
- Read latency, from accept edge to readdatavalid: 1 + OUT_REG active cycles.
- Each read beat is presented for exactly one active cycle; frozen cycles do not count.
- Reset (synchronous):
  - FSM → IDLE; beat/address counters cleared.
  - Read pipelines flushed; outstanding beats are dropped.
  - readdatavalid = 0; s1_waitrequest = 1 during reset, 0 on the first active cycle after.
  - readdata = 0 when OUT_REG = 1 (don't-care when valid = 0).
  - RAM contents are preserved.
- s1 FSM states: IDLE, RD_BURST, WR_BURST.
  - IDLE: waitrequest = 0.
    - Read accepted (chipselect & read): latch addr and count B. If B = 1, single read and stay in IDLE; else issue beat 0 and go to RD_BURST.
    - Write accepted: write beat 0 at addr. If B > 1, latch base and remaining count and go to WR_BURST.
    - read & write both asserted: write wins; read is ignored.
  - RD_BURST: waitrequest = 1; one read per active cycle at base+k; after beat B-1 issues, return to IDLE.
  - WR_BURST: waitrequest = 0.
    - Each active cycle with chipselect & write writes beat k at base+k; idle cycles are allowed.
    - s1_address and s1_burstcount are ignored on later beats.
    - s1_read is ignored.
    - Return to IDLE after the last beat.
- Burst addresses increment modulo DEPTH: from DEPTH-1 they wrap to 0.
- s2: no waitrequest; one access per active cycle; write wins over read as on s1.
- Byte lanes: only enabled lanes are written.
- Same-cycle writes to the same address on both ports:
  - s1 lanes take precedence.
  - s2 writes only the lanes that s1 does not enable.
- Read-during-write, same port or mixed ports: returns OLD data.
- Addresses ≥ DEPTH: writes are dropped; reads return 0 with normal latency and valid.

Decomposition:
- Package nios_onchip_ram_pkg:
  - s1 state enum (IDLE, RD_BURST, WR_BURST).
  - Function be_width(DATA_W).
  - Function merge_be for the collision lane merge.
- Sub-module nios_onchip_ram_burst_ctrl: s1 FSM, beat counter, wrapping address generator.
- Top level: RAM array inference, s2 path, collision merge, OUT_REG pipelines.

Test Plan:
1. Reset, then s1 single write 0xDEADBEEF at addr 5 with BE 4'b1111; then s1 read addr 5 → readdatavalid exactly 1 cycle, data 0xDEADBEEF, at 1 + OUT_REG cycles after accept.
2. s1 read burst, addr DEPTH-2, burstcount 4 → waitrequest high 3 cycles; 4 consecutive valids with data from addr DEPTH-2, DEPTH-1, 0, 1.
3. s1 write burst of 4 to addr 0x10 with one idle cycle after beat 1 and clken = 0 for 2 cycles mid-burst → words 0x10–0x13 written; no spurious writes; readback matches.
4. Same cycle: s1 writes 0x11223344 BE 4'b0011 and s2 writes 0xAABBCCDD BE 4'b1111, both to addr 7 → word 7 = 0xAABB3344.
5. s2 reads addr 7 while s1 writes 0x0 to addr 7 in the same cycle → s2_readdata = old value; a later read returns 0x0.
6. reset asserted during beat 2 of an 8-beat s1 read burst → no further readdatavalid; FSM returns to IDLE; s1_waitrequest = 0 on the first active cycle after reset; RAM contents unchanged.
